pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage 64-bit pipeline. Each cycle it decides whether each pipeline register loads, holds, or is bubbled/flushed. It arbitrates between three hazard sources: multi-cycle data-memory accesses, taken branches/jumps resolved in EX, and load-use dependencies. It also keeps saturating stall and flush event counters for performance debug.

---
 rtl/pipeline_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: arbitrates memory freezes,
// taken-branch flushes and load-use bubbles, and keeps saturating event counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             mem_access,
  input  logic             branch_taken,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rd,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_use_rs1,
  input  logic             if_id_use_rs2,
  output logic             pc_en,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_en,
  output logic             mem_stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  // WAIT covers the freeze cycles after the first one, minus the final one
  // that hands over to RELEASE.
  localparam logic [3:0] LAT_INIT = (MEM_LAT > 2) ? 4'(MEM_LAT - 2) : 4'd0;
  localparam bit         HAS_FREEZE = (MEM_LAT > 1);
  localparam bit         SHORT_LAT  = (MEM_LAT == 2);

  state_e           state_q, state_d;
  logic [3:0]       lat_cnt_q, lat_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic freeze;
  logic load_use;
  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = if_id_use_rs1 && (if_id_rs1 == id_ex_rd);
  assign rs2_hit  = if_id_use_rs2 && (if_id_rs2 == id_ex_rd);
  assign load_use = id_ex_memread && (id_ex_rd != 5'd0) && (rs1_hit || rs2_hit);
  assign freeze   = (state_q == RUN && mem_access && HAS_FREEZE) || (state_q == WAIT);

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    case (state_q)
      RUN: begin
        if (freeze) begin
          if (SHORT_LAT) begin
            state_d = RELEASE;
          end else begin
            state_d   = WAIT;
            lat_cnt_d = LAT_INIT;
          end
        end
      end
      WAIT: begin
        lat_cnt_d = lat_cnt_q - 4'd1;
        if (lat_cnt_q == 4'd1) state_d = RELEASE;
      end
      RELEASE: state_d = RUN;
      default: begin
        state_d   = RUN;
        lat_cnt_d = 4'd0;
      end
    endcase
  end

  // Freeze dominates; a branch outranks a load-use bubble.
  always_comb begin
    pc_en        = 1'b1;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_en      = 1'b1;
    mem_stall    = 1'b0;
    if (freeze) begin
      pc_en      = 1'b0;
      if_id_hold = 1'b1;
      pipe_en    = 1'b0;
      mem_stall  = 1'b1;
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use) begin
      pc_en        = 1'b0;
      if_id_hold   = 1'b1;
      id_ex_bubble = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (branch_taken && !freeze && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= RUN;
      lat_cnt_q   <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: several latency configurations share
// one stimulus stream; each step checks hand-computed control/counter values.
module tb_pipeline_hazard_ctrl;

  localparam logic [5:0] IDLE = 6'b100010; // {pc_en,hold,flush,bubble,pipe_en,mem_stall}
  localparam logic [5:0] FRZ  = 6'b010001;
  localparam logic [5:0] LU   = 6'b010110;
  localparam logic [5:0] BR   = 6'b101110;

  logic       clk;
  logic       arst_n;
  logic       mem_access;
  logic       branch_taken;
  logic       id_ex_memread;
  logic [4:0] id_ex_rd;
  logic [4:0] if_id_rs1;
  logic [4:0] if_id_rs2;
  logic       if_id_use_rs1;
  logic       if_id_use_rs2;

  int vectors = 0;
  int errors  = 0;

  logic [5:0]  ctl1, ctl2, ctl3, ctl4;
  logic [31:0] st1, fl1, st3, fl3, st4, fl4;
  logic [1:0]  st2s, fl2s;
  logic [1:0]  ds1, ds2, ds3, ds4;

  pipeline_hazard_ctrl #(.MEM_LAT(1), .CNT_W(32)) u_lat1 (
    .clk(clk), .arst_n(arst_n), .mem_access(mem_access), .branch_taken(branch_taken),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd), .if_id_rs1(if_id_rs1),
    .if_id_rs2(if_id_rs2), .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
    .pc_en(ctl1[5]), .if_id_hold(ctl1[4]), .if_id_flush(ctl1[3]), .id_ex_bubble(ctl1[2]),
    .pipe_en(ctl1[1]), .mem_stall(ctl1[0]), .stall_cnt(st1), .flush_cnt(fl1), .dbg_state(ds1));

  pipeline_hazard_ctrl #(.MEM_LAT(2), .CNT_W(2)) u_lat2s (
    .clk(clk), .arst_n(arst_n), .mem_access(mem_access), .branch_taken(branch_taken),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd), .if_id_rs1(if_id_rs1),
    .if_id_rs2(if_id_rs2), .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
    .pc_en(ctl2[5]), .if_id_hold(ctl2[4]), .if_id_flush(ctl2[3]), .id_ex_bubble(ctl2[2]),
    .pipe_en(ctl2[1]), .mem_stall(ctl2[0]), .stall_cnt(st2s), .flush_cnt(fl2s), .dbg_state(ds2));

  pipeline_hazard_ctrl #(.MEM_LAT(3), .CNT_W(32)) u_lat3 (
    .clk(clk), .arst_n(arst_n), .mem_access(mem_access), .branch_taken(branch_taken),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd), .if_id_rs1(if_id_rs1),
    .if_id_rs2(if_id_rs2), .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
    .pc_en(ctl3[5]), .if_id_hold(ctl3[4]), .if_id_flush(ctl3[3]), .id_ex_bubble(ctl3[2]),
    .pipe_en(ctl3[1]), .mem_stall(ctl3[0]), .stall_cnt(st3), .flush_cnt(fl3), .dbg_state(ds3));

  pipeline_hazard_ctrl #(.MEM_LAT(4), .CNT_W(32)) u_lat4 (
    .clk(clk), .arst_n(arst_n), .mem_access(mem_access), .branch_taken(branch_taken),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd), .if_id_rs1(if_id_rs1),
    .if_id_rs2(if_id_rs2), .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
    .pc_en(ctl4[5]), .if_id_hold(ctl4[4]), .if_id_flush(ctl4[3]), .id_ex_bubble(ctl4[2]),
    .pipe_en(ctl4[1]), .mem_stall(ctl4[0]), .stall_cnt(st4), .flush_cnt(fl4), .dbg_state(ds4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    mem_access    = 1'b0;
    branch_taken  = 1'b0;
    id_ex_memread = 1'b0;
    id_ex_rd      = 5'd0;
    if_id_rs1     = 5'd0;
    if_id_rs2     = 5'd0;
    if_id_use_rs1 = 1'b0;
    if_id_use_rs2 = 1'b0;
  endtask

  initial begin
    arst_n = 1'b0;
    clear_inputs();

    // Reset with all inputs low.
    @(negedge clk); #2;
    chk("rst_ctl1", 32'(ctl1), 32'(IDLE));
    chk("rst_ctl2", 32'(ctl2), 32'(IDLE));
    chk("rst_ctl3", 32'(ctl3), 32'(IDLE));
    chk("rst_ctl4", 32'(ctl4), 32'(IDLE));
    chk("rst_st4", st4, 32'd0);
    chk("rst_fl4", fl4, 32'd0);
    chk("rst_st2s", 32'(st2s), 32'd0);
    chk("rst_state4", 32'(ds4), 32'd0);

    // MEM_LAT=4 with access held: 3 frozen, 1 release, then frozen again.
    @(negedge clk);
    arst_n     = 1'b1;
    mem_access = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk($sformatf("lat4_ctl_c%0d", i), 32'(ctl4), (i == 3) ? 32'(IDLE) : 32'(FRZ));
      chk($sformatf("lat1_ctl_c%0d", i), 32'(ctl1), 32'(IDLE));
      if (i == 1) chk("lat4_state_wait", 32'(ds4), 32'd1);
      if (i == 3) begin
        chk("lat4_state_release", 32'(ds4), 32'd2);
        chk("lat4_stall_after_seq", st4, 32'd3);
      end
      @(negedge clk);
    end
    #2;
    chk("lat4_state_wait2", 32'(ds4), 32'd1);
    chk("lat4_stall_4", st4, 32'd4);
    chk("lat1_stall_none", st1, 32'd0);

    // Asynchronous reset in the middle of WAIT.
    #1 arst_n = 1'b0;
    mem_access = 1'b0;
    #1;
    chk("arst_state4", 32'(ds4), 32'd0);
    chk("arst_st4", st4, 32'd0);
    chk("arst_ctl4", 32'(ctl4), 32'(IDLE));
    @(negedge clk);
    arst_n = 1'b1;
    #2;
    chk("post_rst_ctl4", 32'(ctl4), 32'(IDLE));
    @(negedge clk); #2;
    chk("post_rst_ctl4_b", 32'(ctl4), 32'(IDLE));

    // Load-use on rs2.
    @(negedge clk);
    id_ex_memread = 1'b1; id_ex_rd = 5'd5; if_id_rs2 = 5'd5; if_id_use_rs2 = 1'b1;
    #2;
    chk("lu_rs2_ctl4", 32'(ctl4), 32'(LU));
    // rd == x0 never hazards.
    @(negedge clk);
    id_ex_rd = 5'd0; if_id_rs1 = 5'd0; if_id_use_rs1 = 1'b1; if_id_rs2 = 5'd0;
    #2;
    chk("lu_x0_ctl4", 32'(ctl4), 32'(IDLE));
    chk("lu_stall_cnt", st4, 32'd1);
    // Matching rs1 that the instruction does not read.
    @(negedge clk);
    id_ex_rd = 5'd7; if_id_rs1 = 5'd7; if_id_use_rs1 = 1'b0; if_id_rs2 = 5'd3;
    #2;
    chk("lu_unused_rs1", 32'(ctl4), 32'(IDLE));
    // Match without a load in ID/EX.
    @(negedge clk);
    id_ex_memread = 1'b0; if_id_use_rs1 = 1'b1;
    #2;
    chk("lu_no_load", 32'(ctl4), 32'(IDLE));
    // Load-use on rs1.
    @(negedge clk);
    id_ex_memread = 1'b1;
    #2;
    chk("lu_rs1_ctl4", 32'(ctl4), 32'(LU));

    // Branch overrides a simultaneous load-use.
    @(negedge clk);
    id_ex_rd = 5'd9; if_id_rs1 = 5'd9; branch_taken = 1'b1;
    #2;
    chk("br_lu_ctl4", 32'(ctl4), 32'(BR));
    chk("br_fl4_before", fl4, 32'd0);
    @(negedge clk);
    clear_inputs();
    #2;
    chk("br_fl4_after", fl4, 32'd1);
    chk("br_fl3_after", fl3, 32'd1);
    chk("br_st4_after", st4, 32'd2);

    // Branch during a MEM_LAT=3 freeze is acted on only in RELEASE.
    @(negedge clk);
    mem_access = 1'b1; branch_taken = 1'b1;
    #2;
    chk("lat3_br_frz0", 32'(ctl3), 32'(FRZ));
    @(negedge clk); #2;
    chk("lat3_br_frz1", 32'(ctl3), 32'(FRZ));
    chk("lat3_state_wait", 32'(ds3), 32'd1);
    @(negedge clk); #2;
    chk("lat3_br_release", 32'(ctl3), 32'(BR));
    chk("lat3_state_release", 32'(ds3), 32'd2);
    chk("lat3_fl_during", fl3, 32'd1);
    @(negedge clk);
    clear_inputs();
    #2;
    chk("lat3_fl_once", fl3, 32'd2);
    chk("lat3_st", st3, 32'd4);
    chk("lat3_ctl_idle", 32'(ctl3), 32'(IDLE));

    // Counter saturation on a 2-bit MEM_LAT=2 instance.
    @(negedge clk);
    arst_n = 1'b0;
    #2 arst_n = 1'b1;
    @(negedge clk);
    mem_access = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #2;
      chk($sformatf("lat2_ctl_c%0d", i), 32'(ctl2), (i % 2 == 0) ? 32'(FRZ) : 32'(IDLE));
      chk($sformatf("lat1_acc_c%0d", i), 32'(ctl1), 32'(IDLE));
      @(negedge clk);
    end
    mem_access = 1'b0;
    #2;
    chk("lat2_stall_sat", 32'(st2s), 32'd3);
    chk("lat1_stall_zero", st1, 32'd0);
    @(negedge clk);
    branch_taken = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk($sformatf("lat2_br_c%0d", i), 32'(ctl2), 32'(BR));
      @(negedge clk);
    end
    branch_taken = 1'b0;
    #2;
    chk("lat2_flush_sat", 32'(fl2s), 32'd3);
    chk("lat4_flush_5", fl4, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
